// File: rtl/iir_coeff_loader_if.sv
// Coefficient configuration stream interface for iir_coeff_loader.
// Carries one signed coefficient word per transfer with a frame marker.
//   cfg_valid : a coefficient word is offered
//   cfg_ready : the loader accepts the word (transfer on valid & ready)
//   cfg_data  : the coefficient word, two's complement
//   cfg_last  : marks the final word of a frame
interface iir_coeff_loader_if #(
  parameter int COEFF_WIDTH = 32
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [COEFF_WIDTH-1:0] cfg_data;
  logic                   cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/iir_coeff_loader.sv
// Double-buffered coefficient loader for a cascade of biquad sections.
// Words arrive over the cfg stream into a shadow bank.  A complete frame of
// exactly 5*NUM_SECTIONS words waits for sample_tick, then the whole shadow
// bank is copied to the active bank on one edge so the filter never sees a
// mix of old and new coefficients.  Short and long frames are rejected.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   cfg            : coefficient stream (slave side)
//   sample_tick    : filter sample boundary strobe
//   coeff_out      : active coefficients, word k at [k*COEFF_WIDTH +: COEFF_WIDTH],
//                    section s = words 5s..5s+4 ordered b0,b1,b2,a1,a2
//   commit_pending : a complete frame is waiting for sample_tick
//   commit_done    : one-cycle pulse in the cycle after the active bank updates
//   cfg_error      : one-cycle pulse on a malformed frame
module iir_coeff_loader #(
  parameter int COEFF_WIDTH  = 32,
  parameter int NUM_SECTIONS = 2,
  parameter int SCALE_SHIFT  = 20
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  iir_coeff_loader_if.slave                     cfg,
  input  logic                                  sample_tick,
  output logic [5*NUM_SECTIONS*COEFF_WIDTH-1:0] coeff_out,
  output logic                                  commit_pending,
  output logic                                  commit_done,
  output logic                                  cfg_error
);

  localparam int N      = 5 * NUM_SECTIONS;
  localparam int BANK_W = N * COEFF_WIDTH;
  localparam int WCW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [WCW-1:0]         WCNT_LAST  = WCW'(N - 1);
  localparam logic [WCW-1:0]         WCNT_ZERO  = {WCW{1'b0}};
  localparam logic [WCW-1:0]         WCNT_ONE   = {{(WCW-1){1'b0}}, 1'b1};
  localparam logic [COEFF_WIDTH-1:0] WORD_ZERO  = {COEFF_WIDTH{1'b0}};
  localparam logic [COEFF_WIDTH-1:0] WORD_ONE   = {{(COEFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COEFF_WIDTH-1:0] UNITY_WORD = WORD_ONE << SCALE_SHIFT;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LOAD        = 2'd1,
    ST_WAIT_COMMIT = 2'd2,
    ST_DRAIN       = 2'd3
  } state_t;

  // Unity pass-through bank: b0 = 1.0 in the fixed-point format, all else 0.
  function automatic logic [BANK_W-1:0] unity_bank();
    logic [BANK_W-1:0] b;
    b = {BANK_W{1'b0}};
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      b[(5 * s) * COEFF_WIDTH +: COEFF_WIDTH] = UNITY_WORD;
    end
    return b;
  endfunction

  state_t                 state_r;
  logic [WCW-1:0]         wcnt_r;
  logic [COEFF_WIDTH-1:0] shadow_r [N];
  logic [BANK_W-1:0]      coeff_r;
  logic [BANK_W-1:0]      shadow_flat_s;
  logic                   cfg_ready_r;
  logic                   commit_pending_r;
  logic                   commit_done_r;
  logic                   cfg_error_r;
  logic                   accept_s;

  assign accept_s       = cfg.cfg_valid & cfg_ready_r;
  assign cfg.cfg_ready  = cfg_ready_r;
  assign coeff_out      = coeff_r;
  assign commit_pending = commit_pending_r;
  assign commit_done    = commit_done_r;
  assign cfg_error      = cfg_error_r;

  // Flatten the shadow bank into the coeff_out word layout.
  always_comb begin
    shadow_flat_s = {BANK_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      shadow_flat_s[k * COEFF_WIDTH +: COEFF_WIDTH] = shadow_r[k];
    end
  end

  // Frame-loading FSM with shadow/active banks and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      wcnt_r           <= WCNT_ZERO;
      cfg_ready_r      <= 1'b1;
      commit_pending_r <= 1'b0;
      commit_done_r    <= 1'b0;
      cfg_error_r      <= 1'b0;
      coeff_r          <= unity_bank();
      for (int k = 0; k < N; k++) begin
        shadow_r[k] <= WORD_ZERO;
      end
    end else begin
      // Pulses default low; the branches below raise them for one cycle.
      commit_done_r <= 1'b0;
      cfg_error_r   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_LOAD: begin
          if (accept_s) begin
            shadow_r[wcnt_r] <= cfg.cfg_data;
            if (cfg.cfg_last) begin
              wcnt_r <= WCNT_ZERO;
              if (wcnt_r == WCNT_LAST) begin
                // Complete frame: hold off the stream until it is committed.
                state_r          <= ST_WAIT_COMMIT;
                cfg_ready_r      <= 1'b0;
                commit_pending_r <= 1'b1;
              end else begin
                // Short frame: abandon it, active bank keeps its values.
                state_r     <= ST_IDLE;
                cfg_error_r <= 1'b1;
              end
            end else if (wcnt_r == WCNT_LAST) begin
              // Long frame: discard the rest up to the next cfg_last.
              state_r     <= ST_DRAIN;
              cfg_error_r <= 1'b1;
              wcnt_r      <= WCNT_ZERO;
            end else begin
              state_r <= ST_LOAD;
              wcnt_r  <= wcnt_r + WCNT_ONE;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_WAIT_COMMIT: begin
          // The final-word edge has already passed, so a tick here is at least
          // one cycle later and can never coincide with the final transfer.
          if (sample_tick) begin
            coeff_r          <= shadow_flat_s;
            state_r          <= ST_IDLE;
            cfg_ready_r      <= 1'b1;
            commit_pending_r <= 1'b0;
            commit_done_r    <= 1'b1;
          end else begin
            state_r <= ST_WAIT_COMMIT;
          end
        end
        ST_DRAIN: begin
          if (accept_s && cfg.cfg_last) begin
            state_r <= ST_IDLE;
            wcnt_r  <= WCNT_ZERO;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          wcnt_r           <= WCNT_ZERO;
          cfg_ready_r      <= 1'b1;
          commit_pending_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/iir_coeff_loader.md
IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

Interface
REQ-001 SHALL provide parameter COEFF_WIDTH, default 32, the width of one signed coefficient word.
REQ-002 SHALL provide parameter NUM_SECTIONS, default 2, the number of cascaded biquad sections served; the frame length is N = 5*NUM_SECTIONS words.
REQ-003 SHALL provide parameter SCALE_SHIFT, default 20, the fixed-point position used for the reset coefficient values.
REQ-004 SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port cfg_valid, input, 1: a coefficient word is offered.
REQ-007 SHALL have port cfg_ready, output, 1: the block accepts the word; the word is transferred when cfg_valid and cfg_ready are both high.
REQ-008 SHALL have port cfg_data, input, COEFF_WIDTH: the coefficient word, two's complement.
REQ-009 SHALL have port cfg_last, input, 1: marks the final word of a frame.
REQ-010 SHALL have port sample_tick, input, 1: a one-cycle strobe marking the filter sample boundary.
REQ-011 SHALL have port coeff_out, output, N*COEFF_WIDTH: the active coefficients; section s occupies words 5s..5s+4 in the order b0,b1,b2,a1,a2, and word k sits at bits [k*COEFF_WIDTH +: COEFF_WIDTH].
REQ-012 SHALL have port commit_pending, output, 1: a complete frame is waiting for sample_tick.
REQ-013 SHALL have port commit_done, output, 1: a one-cycle pulse in the cycle after the active bank updates.
REQ-014 SHALL have port cfg_error, output, 1: a one-cycle pulse on a malformed frame.

Function
REQ-015 SHALL implement the states IDLE, LOAD, WAIT_COMMIT and DRAIN, with a word counter wcnt ranging 0..N-1.
REQ-016 SHALL drive cfg_ready high in IDLE, LOAD and DRAIN, and low in WAIT_COMMIT.
REQ-017 SHALL, on each accepted word in IDLE or LOAD, write cfg_data to shadow word wcnt and increment wcnt; IDLE moves to LOAD on the first accepted word.
REQ-018 SHALL, on an accepted word with wcnt=N-1 and cfg_last=1, move to WAIT_COMMIT and clear wcnt.
REQ-019 SHALL, on an accepted word with cfg_last=1 and wcnt<N-1 (short frame), pulse cfg_error, clear wcnt, and return to IDLE; the shadow bank contents are don't-care and the active bank is unchanged.
REQ-020 SHALL, on an accepted word with wcnt=N-1 and cfg_last=0 (long frame), pulse cfg_error and move to DRAIN.
REQ-021 SHALL, in DRAIN, accept and discard words until a word with cfg_last=1 is accepted, then clear wcnt and return to IDLE.
REQ-022 SHALL drive commit_pending high exactly while the state is WAIT_COMMIT.
REQ-023 SHALL, in WAIT_COMMIT with sample_tick=1, copy all N shadow words to the active bank on that edge, move to IDLE, and pulse commit_done in the next cycle.
REQ-024 SHALL ignore sample_tick in IDLE, LOAD and DRAIN.
REQ-025 SHALL NOT commit on a sample_tick that coincides with acceptance of the final word; the minimum latency from the final-word edge to the active-bank update is 1 cycle.
REQ-026 SHALL update all N active words on a single edge, with no partial update observable on coeff_out.
REQ-027 SHALL drive coeff_out directly from registers, with no combinational path from any input.
REQ-028 SHALL store coefficient words unmodified, with no width conversion or saturation.

Reset
REQ-029 SHALL, on rst_n low, immediately force: state IDLE, wcnt 0, commit_pending 0, commit_done 0, cfg_error 0, and cfg_ready 1 once reset is released.
REQ-030 SHALL reset the active bank to unity pass-through: each section's b0 = 1<<SCALE_SHIFT and b1, b2, a1, a2 = 0.
REQ-031 SHALL discard any partially loaded or pending frame when reset is asserted mid-operation, leaving the active bank at the unity values.

Verification
REQ-032 SHALL cover this scenario: after reset, check that coeff_out word 0 = 0x00100000, word 5 = 0x00100000, and all other words are 0.
REQ-033 SHALL cover this scenario: send 10 words 1..10 back-to-back with cfg_last on word 10, then pulse sample_tick 3 cycles later -> commit_pending is high for 3 cycles, coeff_out word k = k+1 on the following edge, and commit_done pulses once.
REQ-034 SHALL cover this scenario: send 4 words with cfg_last on word 4 -> cfg_error pulses once, the state is IDLE, and coeff_out is unchanged; then a subsequent valid 10-word frame commits correctly.
REQ-035 SHALL cover this scenario: send 12 words with cfg_last only on word 12 -> cfg_error pulses after word 10, words 11-12 are accepted and discarded, commit_pending never rises, and coeff_out is unchanged.
REQ-036 SHALL cover this scenario: hold sample_tick high during the final-word transfer -> no commit occurs; the next sample_tick commits, and cfg_valid is held with cfg_ready low meanwhile.
REQ-037 SHALL cover this scenario: assert rst_n low while in WAIT_COMMIT -> coeff_out shows the unity values and commit_pending = 0 with no sample_tick needed.
